// File: rtl/pe_act_receiver.sv
// rtl/pe_act_receiver.sv - PE receive side: activation flits to queue, partial sums into rank buffer
// Optional macro RX_PS_SATURATE_EN: saturating partial-sum accumulation (default: two's-complement wrap).
module pe_act_receiver #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 10,
   parameter int SRC_W  = 6,
   parameter int RANK_W = 5,
   parameter int CNT_W  = 12
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_start,
   input  logic [CNT_W-1:0]        cfg_act_expect,
   input  logic [CNT_W-1:0]        cfg_ps_expect,
   input  logic                    rx_valid,
   output logic                    rx_rdy,
   input  logic                    rx_type,
   input  logic [SRC_W-1:0]        rx_src,
   input  logic [IDX_W-1:0]        rx_idx,
   input  logic [DATA_W-1:0]       rx_data,
   input  logic                    queue_full,
   output logic                    queue_push,
   output logic [IDX_W+DATA_W-1:0] queue_data,
   input  logic                    ps_read_en,
   input  logic [RANK_W-1:0]       ps_read_addr,
   output logic [DATA_W-1:0]       ps_read_data,
   output logic                    busy,
   output logic                    rx_done,
   output logic                    err_unexpected
);
   localparam int DEPTH = 2**RANK_W;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RECV, S_DONE} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_act_exp;
   logic [CNT_W-1:0]    r_ps_exp;
   logic [CNT_W-1:0]    r_act_cnt;
   logic [CNT_W-1:0]    r_ps_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic [DATA_W-1:0]   r_ps_buf [DEPTH];
   logic [DATA_W-1:0]   r_ps_rd;

   logic                w_start;
   logic                w_rdy;
   logic                w_xfer;
   logic                w_act_xfer;
   logic                w_ps_xfer;
   logic                w_act_full;
   logic                w_ps_full;
   logic                w_over;
   logic [CNT_W-1:0]    w_act_nxt;
   logic [CNT_W-1:0]    w_ps_nxt;
   logic                w_layer_done;
   logic [RANK_W-1:0]   w_rank;
   logic [DATA_W-1:0]   w_cur;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_ps_new;
   logic                w_unused;

   assign w_start    = rx_start && (r_state == S_IDLE);
   assign w_rdy      = (r_state == S_RECV) && (rx_type || !queue_full);
   assign w_xfer     = rx_valid && w_rdy;
   assign w_act_xfer = w_xfer && !rx_type;
   assign w_ps_xfer  = w_xfer && rx_type;

   // Counters hold at their expectation so an overflow flit of one type
   // cannot stop the other type from completing the layer.
   assign w_act_full = (r_act_cnt == r_act_exp);
   assign w_ps_full  = (r_ps_cnt == r_ps_exp);
   assign w_over     = (w_act_xfer && w_act_full) || (w_ps_xfer && w_ps_full);
   assign w_act_nxt  = (w_act_xfer && !w_act_full) ? r_act_cnt + CNT_W'(1) : r_act_cnt;
   assign w_ps_nxt   = (w_ps_xfer && !w_ps_full) ? r_ps_cnt + CNT_W'(1) : r_ps_cnt;
   assign w_layer_done = (w_act_nxt == r_act_exp) && (w_ps_nxt == r_ps_exp);

   assign rx_rdy         = w_rdy;
   assign queue_push     = w_act_xfer;
   assign queue_data     = w_act_xfer ? {rx_idx, rx_data} : '0;
   assign busy           = r_busy;
   assign rx_done        = r_done;
   assign err_unexpected = r_err;
   assign ps_read_data   = r_ps_rd;

   assign w_rank = rx_idx[RANK_W-1:0];
   assign w_cur  = r_ps_buf[w_rank];
   assign w_sum  = {w_cur[DATA_W-1], w_cur} + {rx_data[DATA_W-1], rx_data};

`ifdef RX_PS_SATURATE_EN
   localparam logic [DATA_W-1:0] PS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] PS_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   always_comb begin
      w_ps_new = w_sum[DATA_W-1:0];
      if (w_sum[DATA_W] != w_sum[DATA_W-1])
         w_ps_new = w_sum[DATA_W] ? PS_MIN : PS_MAX;
   end
`else
   assign w_ps_new = w_sum[DATA_W-1:0];
`endif

   assign w_unused = ^{rx_src, w_sum[DATA_W]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_act_exp <= '0;
         r_ps_exp  <= '0;
         r_act_cnt <= '0;
         r_ps_cnt  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rx_start) begin
                  r_act_exp <= cfg_act_expect;
                  r_ps_exp  <= cfg_ps_expect;
                  r_act_cnt <= '0;
                  r_ps_cnt  <= '0;
                  r_err     <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (r_act_exp == '0 && r_ps_exp == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_RECV;
               end
            end
            S_RECV: begin
               r_act_cnt <= w_act_nxt;
               r_ps_cnt  <= w_ps_nxt;
               if (w_over)
                  r_err <= 1'b1;
               if (w_xfer && w_layer_done) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Flop-based buffer: the read of a back-to-back flit already sees the
   // previous edge's write, so no separate forwarding path is needed.
   always_ff @(posedge clk) begin
      if (w_start) begin
         for (int i = 0; i < DEPTH; i++)
            r_ps_buf[i] <= '0;
      end else if (w_ps_xfer) begin
         r_ps_buf[w_rank] <= w_ps_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ps_rd <= '0;
      else if (ps_read_en)
         r_ps_rd <= r_ps_buf[ps_read_addr];
   end

endmodule

// File: tb/tb_pe_act_receiver.sv
// tb/tb_pe_act_receiver.sv - directed self-checking bench for pe_act_receiver
// Saturation expectation follows RX_PS_SATURATE_EN when the bench is built with it.
module tb_pe_act_receiver;
   logic        clk = 1'b0;
   logic        rst;
   logic        rx_start;
   logic [11:0] cfg_act_expect;
   logic [11:0] cfg_ps_expect;
   logic        rx_valid;
   logic        rx_rdy;
   logic        rx_type;
   logic [5:0]  rx_src;
   logic [9:0]  rx_idx;
   logic [15:0] rx_data;
   logic        queue_full;
   logic        queue_push;
   logic [25:0] queue_data;
   logic        ps_read_en;
   logic [4:0]  ps_read_addr;
   logic [15:0] ps_read_data;
   logic        busy;
   logic        rx_done;
   logic        err_unexpected;

   int n_vec = 0;
   int n_err = 0;

   pe_act_receiver dut (
      .clk(clk), .rst(rst), .rx_start(rx_start),
      .cfg_act_expect(cfg_act_expect), .cfg_ps_expect(cfg_ps_expect),
      .rx_valid(rx_valid), .rx_rdy(rx_rdy), .rx_type(rx_type), .rx_src(rx_src),
      .rx_idx(rx_idx), .rx_data(rx_data), .queue_full(queue_full),
      .queue_push(queue_push), .queue_data(queue_data),
      .ps_read_en(ps_read_en), .ps_read_addr(ps_read_addr), .ps_read_data(ps_read_data),
      .busy(busy), .rx_done(rx_done), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input logic [11:0] a, input logic [11:0] p);
      rx_start = 1'b1;
      cfg_act_expect = a;
      cfg_ps_expect = p;
      tick;
      rx_start = 1'b0;
   endtask

   task automatic ps_read(input logic [4:0] a, output logic [15:0] d);
      ps_read_en = 1'b1;
      ps_read_addr = a;
      tick;
      ps_read_en = 1'b0;
      d = ps_read_data;
   endtask

   task automatic send_flit(input logic t, input logic [9:0] idx, input logic [15:0] d,
                            output logic qp, output logic [25:0] qd);
      bit sent = 1'b0;
      rx_valid = 1'b1;
      rx_type = t;
      rx_idx = idx;
      rx_data = d;
      rx_src = 6'd3;
      qp = 1'b0;
      qd = '0;
      for (int i = 0; i < 20 && !sent; i++) begin
         #1;
         if (rx_rdy) begin
            qp = queue_push;
            qd = queue_data;
            sent = 1'b1;
         end
         tick;
      end
      rx_valid = 1'b0;
      if (!sent) begin
         n_vec++; n_err++;
         $display("FAIL send_flit_timeout: rx_rdy never high for idx %0d (got 0, need 1)", idx);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) tick;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
      n_vec++; if (rx_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b need 0", rx_rdy); end
      n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", rx_done); end
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b need 0", err_unexpected); end
      n_vec++; if (queue_push !== 1'b0 || queue_data !== 26'd0) begin n_err++; $display("FAIL reset_queue: got %b/%h need 0/0", queue_push, queue_data); end
      n_vec++; if (ps_read_data !== 16'd0) begin n_err++; $display("FAIL reset_psrd: got %h need 0", ps_read_data); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_recv;
      logic qp;
      logic [25:0] qd;
      int pulses;
      start_layer(12'd3, 12'd0);
      tick;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b need 1", busy); end
      send_flit(1'b0, 10'd1, 16'd11, qp, qd);
      send_flit(1'b0, 10'd2, 16'd12, qp, qd);
      rx_type = 1'b0;
      rst = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b need 0", busy); end
      n_vec++; if (rx_rdy !== 1'b0) begin n_err++; $display("FAIL midrst_rdy: got %b need 0", rx_rdy); end
      tick;
      rst = 1'b0;
      tick;
      n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b need 0", rx_done); end
      start_layer(12'd3, 12'd0);
      tick;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         send_flit(1'b0, 10'(i), 16'(i), qp, qd);
         if (rx_done) pulses++;
      end
      for (int i = 0; i < 3; i++) begin
         tick;
         if (rx_done) pulses++;
      end
      n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL midrst_relayer_pulses: got %0d need 1", pulses); end
   endtask

   task automatic test_flow_control;
      logic qp;
      logic [25:0] qd;
      start_layer(12'd4, 12'd0);
      tick;
      send_flit(1'b0, 10'd5, 16'h0010, qp, qd);
      n_vec++; if (qp !== 1'b1 || qd !== {10'd5, 16'h0010}) begin n_err++; $display("FAIL flow_flit1: got %b/%h need 1/%h", qp, qd, {10'd5, 16'h0010}); end
      queue_full = 1'b1;
      rx_valid = 1'b1; rx_type = 1'b0; rx_idx = 10'd6; rx_data = 16'h0011;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++; if (rx_rdy !== 1'b0 || queue_push !== 1'b0) begin n_err++; $display("FAIL flow_full_cycle%0d: rdy/push got %b/%b need 0/0", i, rx_rdy, queue_push); end
         tick;
      end
      queue_full = 1'b0;
      #1;
      n_vec++; if (rx_rdy !== 1'b1 || queue_push !== 1'b1 || queue_data !== {10'd6, 16'h0011}) begin n_err++; $display("FAIL flow_flit2: got %b/%b/%h need 1/1/%h", rx_rdy, queue_push, queue_data, {10'd6, 16'h0011}); end
      tick;
      rx_valid = 1'b0;
      send_flit(1'b0, 10'd7, 16'h0012, qp, qd);
      n_vec++; if (qp !== 1'b1 || qd !== {10'd7, 16'h0012}) begin n_err++; $display("FAIL flow_flit3: got %b/%h need 1/%h", qp, qd, {10'd7, 16'h0012}); end
      n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL flow_early_done: got %b need 0", rx_done); end
      send_flit(1'b0, 10'd8, 16'h0013, qp, qd);
      n_vec++; if (qp !== 1'b1 || qd !== {10'd8, 16'h0013}) begin n_err++; $display("FAIL flow_flit4: got %b/%h need 1/%h", qp, qd, {10'd8, 16'h0013}); end
      n_vec++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL flow_done: got %b need 1", rx_done); end
      tick;
      n_vec++; if (rx_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL flow_after_done: done/busy got %b/%b need 0/0", rx_done, busy); end
   endtask

   task automatic test_back_to_back;
      logic qp;
      logic [25:0] qd;
      logic [15:0] d;
      start_layer(12'd0, 12'd3);
      tick;
      send_flit(1'b1, 10'd2, 16'd100, qp, qd);
      n_vec++; if (qp !== 1'b0) begin n_err++; $display("FAIL b2b_no_push: got %b need 0", qp); end
      send_flit(1'b1, 10'd2, -16'sd30, qp, qd);
      send_flit(1'b1, 10'd7, 16'd5, qp, qd);
      n_vec++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b need 1", rx_done); end
      ps_read(5'd2, d);
      n_vec++; if (d !== 16'd70) begin n_err++; $display("FAIL b2b_rank2: got %0d need 70", d); end
      ps_read(5'd7, d);
      n_vec++; if (d !== 16'd5) begin n_err++; $display("FAIL b2b_rank7: got %0d need 5", d); end
      ps_read(5'd0, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL b2b_rank0: got %0d need 0", d); end
      ps_read(5'd31, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL b2b_rank31: got %0d need 0", d); end
   endtask

   task automatic test_saturation;
      logic qp;
      logic [25:0] qd;
      logic [15:0] d;
      logic [15:0] exp_sum;
`ifdef RX_PS_SATURATE_EN
      exp_sum = 16'h7FFF;
`else
      exp_sum = 16'h88B8;
`endif
      start_layer(12'd0, 12'd2);
      tick;
      send_flit(1'b1, 10'd0, 16'd30000, qp, qd);
      ps_read_en = 1'b1;
      ps_read_addr = 5'd0;
      send_flit(1'b1, 10'd0, 16'd5000, qp, qd);
      ps_read_en = 1'b0;
      n_vec++; if (ps_read_data !== 16'd30000) begin n_err++; $display("FAIL sat_collision_read: got %0d need 30000", ps_read_data); end
      n_vec++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL sat_done: got %b need 1", rx_done); end
      ps_read(5'd0, d);
      n_vec++; if (d !== exp_sum) begin n_err++; $display("FAIL sat_rank0: got %h need %h", d, exp_sum); end
   endtask

   task automatic test_zero_and_overflow;
      logic qp;
      logic [25:0] qd;
      logic [15:0] d;
      start_layer(12'd0, 12'd0);
      n_vec++; if (rx_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL zero_clear: done/busy got %b/%b need 0/1", rx_done, busy); end
      tick;
      n_vec++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b need 1", rx_done); end
      tick;
      n_vec++; if (rx_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_after: done/busy got %b/%b need 0/0", rx_done, busy); end
      ps_read(5'd0, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL zero_buf_cleared: got %h need 0", d); end
      start_layer(12'd1, 12'd1);
      tick;
      send_flit(1'b0, 10'd1, 16'd1, qp, qd);
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL ovf_err_early: got %b need 0", err_unexpected); end
      send_flit(1'b0, 10'd2, 16'd2, qp, qd);
      n_vec++; if (qp !== 1'b1 || qd !== {10'd2, 16'd2}) begin n_err++; $display("FAIL ovf_still_pushed: got %b/%h need 1/%h", qp, qd, {10'd2, 16'd2}); end
      n_vec++; if (err_unexpected !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ovf_err: err/busy got %b/%b need 1/1", err_unexpected, busy); end
      send_flit(1'b1, 10'd3, 16'd9, qp, qd);
      n_vec++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %b need 1", rx_done); end
      tick;
      n_vec++; if (err_unexpected !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b need 1", err_unexpected); end
   endtask

   task automatic test_mixed;
      logic qp;
      logic [25:0] qd;
      logic [15:0] d;
      start_layer(12'd2, 12'd2);
      rx_valid = 1'b1; rx_type = 1'b0;
      #1;
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL mix_err_cleared: got %b need 0", err_unexpected); end
      n_vec++; if (rx_rdy !== 1'b0) begin n_err++; $display("FAIL mix_clear_rdy: got %b need 0", rx_rdy); end
      tick;
      rx_valid = 1'b0;
      send_flit(1'b0, 10'd40, 16'd1, qp, qd);
      queue_full = 1'b1;
      send_flit(1'b1, 10'd4, 16'd7, qp, qd);
      n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL mix_done_after2: got %b need 0", rx_done); end
      queue_full = 1'b0;
      start_layer(12'd0, 12'd0);
      n_vec++; if (busy !== 1'b1 || rx_done !== 1'b0) begin n_err++; $display("FAIL mix_start_ignored: busy/done got %b/%b need 1/0", busy, rx_done); end
      send_flit(1'b0, 10'd41, 16'd2, qp, qd);
      n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL mix_done_after3: got %b need 0", rx_done); end
      send_flit(1'b1, 10'd4, 16'd8, qp, qd);
      n_vec++; if (rx_done !== 1'b1) begin n_err++; $display("FAIL mix_done: got %b need 1", rx_done); end
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL mix_no_err: got %b need 0", err_unexpected); end
      tick;
      rx_valid = 1'b1; rx_type = 1'b0;
      #1;
      n_vec++; if (rx_rdy !== 1'b0 || queue_push !== 1'b0) begin n_err++; $display("FAIL mix_idle_stray: rdy/push got %b/%b need 0/0", rx_rdy, queue_push); end
      tick;
      rx_valid = 1'b0;
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL mix_idle_stray_err: got %b need 0", err_unexpected); end
      ps_read(5'd4, d);
      n_vec++; if (d !== 16'd15) begin n_err++; $display("FAIL mix_rank4: got %0d need 15", d); end
   endtask

   initial begin
      rst = 1'b1; rx_start = 1'b0; cfg_act_expect = '0; cfg_ps_expect = '0;
      rx_valid = 1'b0; rx_type = 1'b0; rx_src = '0; rx_idx = '0; rx_data = '0;
      queue_full = 1'b0; ps_read_en = 1'b0; ps_read_addr = '0;
      test_reset;
      test_reset_mid_recv;
      test_flow_control;
      test_back_to_back;
      test_saturation;
      test_zero_and_overflow;
      test_mixed;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
      $fatal(1);
   end
endmodule
